// File: rtl/gate_net_arbiter_pkg.sv
// gate_net_pkg: shared widths, FSM encoding and golden gate-network function.
package gate_net_pkg;
    localparam int DP_IN_W = 5;
    localparam int DP_OUT_W = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
    // {out3,out2,out1} from {in5,in4,in3,in2,in1}
    function automatic logic [DP_OUT_W-1:0] gate_net_ref(input logic [DP_IN_W-1:0] in);
        return {in[2] | ~in[3] | in[4], ~(in[1] & in[2]), ~(~(in[0] | in[1]) & in[2])};
    endfunction
endpackage

// File: rtl/gate_net_arbiter_if.sv
// gate_net_arbiter_if: request/grant and valid/ready response bundle.
interface gate_net_arbiter_if
    import gate_net_pkg::*;
#(
    parameter int N = 4,
    parameter int ID_W = $clog2(N)
) ();
    logic [N-1:0] req;
    logic [DP_IN_W*N-1:0] req_data;
    logic [N-1:0] gnt;
    logic rsp_valid;
    logic rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [DP_OUT_W-1:0] rsp_data;
    modport master(output req, req_data, rsp_ready, input gnt, rsp_valid, rsp_id, rsp_data);
    modport slave(input req, req_data, rsp_ready, output gnt, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/gate_net_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting at ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            any_o,
    output logic [ID_W-1:0] idx_o
);
    logic [N-1:0] rot;
    logic [ID_W-1:0] enc;
    logic [ID_W:0] sum;
    always_comb begin
        rot = N'({req_i, req_i} >> ptr_i);
        enc = '0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) enc = k[ID_W-1:0];
        sum = {1'b0, ptr_i} + {1'b0, enc};
        idx_o = sum >= (ID_W+1)'(N) ? ID_W'(sum - (ID_W+1)'(N)) : sum[ID_W-1:0];
    end
    assign any_o = |req_i;
endmodule

// File: rtl/gate_net_arbiter.sv
// gate_net_arbiter: round-robin sharing of one registered gate-network datapath.
module gate_net_arbiter
    import gate_net_pkg::*;
#(
    parameter int N = 4,
    parameter int DP_LAT = 1,
    localparam int ID_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    gate_net_arbiter_if.slave   arb,
    output logic [DP_IN_W-1:0]  dp_in_o,
    input  logic [DP_OUT_W-1:0] dp_out_i
);
    localparam int CNT_W = $clog2(DP_LAT + 1);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, idx;
    logic [N-1:0] gnt_q, gnt_d;
    logic [DP_IN_W-1:0] dp_in_q, dp_in_d;
    logic [DP_OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic rsp_valid_q, rsp_valid_d, any;

    rr_pick #(.N(N)) u_pick (.req_i(arb.req), .ptr_i(ptr_q), .any_o(any), .idx_o(idx));

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        gnt_d = '0;
        dp_in_d = dp_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: if (any) begin
                gnt_d = N'(1) << idx;
                dp_in_d = arb.req_data[int'(idx)*DP_IN_W +: DP_IN_W];
                cnt_d = CNT_W'(DP_LAT);
                rsp_id_d = idx;
                state_d = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                rsp_data_d = dp_out_i;
                rsp_valid_d = 1'b1;
                state_d = RESP;
            end else cnt_d = cnt_q - 1'b1;
            RESP: if (arb.rsp_ready) begin
                rsp_valid_d = 1'b0;
                ptr_d = rsp_id_q == ID_W'(N - 1) ? '0 : rsp_id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ptr_q <= '0;
            gnt_q <= '0;
            dp_in_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            dp_in_q <= dp_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign arb.gnt = gnt_q;
    assign arb.rsp_valid = rsp_valid_q;
    assign arb.rsp_id = rsp_id_q;
    assign arb.rsp_data = rsp_data_q;
    assign dp_in_o = dp_in_q;
endmodule

// File: tb/tb_gate_net_arbiter.sv
// tb_gate_net_arbiter: directed vectors plus hand-written corner sequences.
module tb_gate_net_arbiter;
    import gate_net_pkg::*;
    localparam int N = 4;
    localparam int DP_LAT = 1;

    typedef struct {
        logic [3:0]  req;
        logic [19:0] data;
        logic [3:0]  gnt;
        int          id;
        logic [4:0]  dp;
        logic [2:0]  rsp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] dp_in;
    logic [2:0] dp_out;
    int total = 0;
    int bad = 0;
    vec_t v[7];

    gate_net_arbiter_if #(.N(N)) bus ();
    gate_net_arbiter #(.N(N), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .rst(rst), .arb(bus), .dp_in_o(dp_in), .dp_out_i(dp_out)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) dp_out <= gate_net_ref(dp_in);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic get_gnt(input logic [3:0] eg, input logic [4:0] ed, input bit hold,
                           input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == '0 && n < 10);
        chk({nm, ".gnt"}, 32'(bus.gnt), 32'(eg));
        chk({nm, ".dp_in"}, 32'(dp_in), 32'(ed));
        if (!hold) bus.req = '0;
    endtask

    task automatic get_rsp(input int id, input logic [2:0] ed, input string nm, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({nm, ".gnt_pulse"}, 32'(bus.gnt), 0);
        end while (!bus.rsp_valid && lat < 20);
        chk({nm, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
        chk({nm, ".rsp_id"}, 32'(bus.rsp_id), 32'(id));
        chk({nm, ".rsp_data"}, 32'(bus.rsp_data), 32'(ed));
    endtask

    initial begin
        int n, lat;
        v[0] = '{4'b0010, {5'b00000, 5'b00000, 5'b00100, 5'b00000}, 4'b0010, 1, 5'b00100, 3'b110};
        v[1] = '{4'b0100, {5'b00000, 5'b11111, 5'b00000, 5'b00000}, 4'b0100, 2, 5'b11111, 3'b101};
        v[2] = '{4'b0101, {5'b00000, 5'b10110, 5'b00000, 5'b00011}, 4'b0001, 0, 5'b00011, 3'b111};
        v[3] = '{4'b0100, {5'b00000, 5'b10110, 5'b00000, 5'b00000}, 4'b0100, 2, 5'b10110, 3'b101};
        v[4] = '{4'b1001, {5'b00000, 5'b00000, 5'b00000, 5'b11000}, 4'b1000, 3, 5'b00000, 3'b111};
        v[5] = '{4'b1010, {5'b11111, 5'b00000, 5'b01100, 5'b00000}, 4'b0010, 1, 5'b01100, 3'b110};
        v[6] = '{4'b1000, {5'b01011, 5'b00000, 5'b00000, 5'b00000}, 4'b1000, 3, 5'b01011, 3'b011};

        // reset held with every requester asserted
        bus.req = 4'b1111;
        bus.req_data = {4{5'b01000}};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.gnt", 32'(bus.gnt), 0);
            chk("rst.rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst.dp_in", 32'(dp_in), 0);
        end
        rst = 1'b0;

        // round robin with all requests held, starting from ptr=0
        for (int k = 0; k < 5; k++) begin
            get_gnt(4'(1 << (k % 4)), 5'b01000, 1'b1, "rr", n);
            if (k == 0) chk("rr.first_gnt_latency", 32'(n), 1);
            chk("rr.onehot", 32'($countones(bus.gnt)), 1);
            if (k == 4) bus.req = '0;
            get_rsp(k % 4, 3'b011, "rr", lat);
        end

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.req_data = v[i].data;
            bus.req = v[i].req;
            get_gnt(v[i].gnt, v[i].dp, 1'b0, $sformatf("vec%0d", i), n);
            get_rsp(v[i].id, v[i].rsp, $sformatf("vec%0d", i), lat);
            if (i == 0) chk("vec0.rsp_latency", 32'(lat), 2);
        end

        // back-pressure: result must hold while the consumer stalls
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_data = {5'b00000, 5'b00000, 5'b00000, 5'b00100};
        bus.req = 4'b0001;
        get_gnt(4'b0001, 5'b00100, 1'b0, "bp", n);
        get_rsp(0, 3'b110, "bp", lat);
        for (int i = 0; i < 10; i++) begin
            bus.req = 4'b1111;
            @(negedge clk);
            chk("bp.hold_valid", 32'(bus.rsp_valid), 1);
            chk("bp.hold_id", 32'(bus.rsp_id), 0);
            chk("bp.hold_data", 32'(bus.rsp_data), 32'(3'b110));
            chk("bp.no_gnt", 32'(bus.gnt), 0);
        end
        bus.req = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.valid_drop", 32'(bus.rsp_valid), 0);
        bus.req_data = {5'b00000, 5'b00000, 5'b01100, 5'b00000};
        bus.req = 4'b0010;
        get_gnt(4'b0010, 5'b01100, 1'b0, "bp_next", n);
        chk("bp.idle_next_cycle", 32'(n), 1);
        get_rsp(1, 3'b110, "bp_next", lat);

        // reset while the datapath result is still pending
        @(negedge clk);
        bus.req_data = {5'b00000, 5'b11111, 5'b00000, 5'b00000};
        bus.req = 4'b0100;
        get_gnt(4'b0100, 5'b11111, 1'b0, "abort", n);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.gnt", 32'(bus.gnt), 0);
        chk("abort.dp_in", 32'(dp_in), 0);
        chk("abort.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("abort.rsp_id", 32'(bus.rsp_id), 0);
        chk("abort.rsp_data", 32'(bus.rsp_data), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort.no_rsp", 32'(bus.rsp_valid), 0);
        end
        bus.req_data = {5'b00000, 5'b00000, 5'b00000, 5'b01000};
        bus.req = 4'b1001;
        get_gnt(4'b0001, 5'b01000, 1'b0, "abort_ptr", n);
        get_rsp(0, 3'b011, "abort_ptr", lat);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
